// File: rtl/one_to_four_demux.sv
// ----------------------------------------------------------------------------
// one_to_four_demux
//
// Routes a valid/ready input stream to one of four output lanes chosen by
// in_sel. Each lane has a single-entry holding register and a full flag, and
// can accept a new transfer in the same cycle its held transfer is consumed,
// so every lane sustains one transfer per cycle. Each lane also counts its
// output handshakes in a saturating counter.
//
// Parameters
//   WIDTH  : payload bits per transfer
//   CNT_W  : width of each per-lane delivery counter
//
// Ports
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         upstream presents a transfer
//   in_ready   out  1         transfer is accepted this cycle (combinational)
//   in_sel     in   2         destination lane 0..3
//   in_data    in   WIDTH     payload
//   out_valid  out  4         bit i: lane i holds a transfer
//   out_ready  in   4         bit i: lane i consumer takes the held transfer
//   out_data   out  4*WIDTH   lane i payload at [i*WIDTH +: WIDTH]
//   out_count  out  4*CNT_W   lane i delivery count at [i*CNT_W +: CNT_W]
// ----------------------------------------------------------------------------
module one_to_four_demux #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0]   out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       full_r;
  logic [WIDTH-1:0] data_r  [4];
  logic [CNT_W-1:0] count_r [4];

  logic             in_ready_s;
  logic [3:0]       load_s;
  logic [3:0]       hs_s;

  // Input-side ready: the selected lane is empty or is being drained now.
  // While in reset all full flags are clear, so this reads 1.
  always_comb begin
    in_ready_s = 1'b0;
    if (!full_r[in_sel] || out_ready[in_sel]) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign in_ready = in_ready_s;

  // Per-lane load strobe (only the selected lane) and output handshake.
  always_comb begin
    load_s = 4'b0000;
    hs_s   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (in_valid && in_ready_s && (in_sel == 2'(i))) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
      hs_s[i] = full_r[i] & out_ready[i];
    end
  end

  // Lane holding registers and full flags. A load wins over a drain, which
  // keeps the lane full across a simultaneous consume-and-refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_s[i]) begin
          full_r[i] <= 1'b1;
          data_r[i] <= in_data;
        end else if (hs_s[i]) begin
          full_r[i] <= 1'b0;
        end else begin
          full_r[i] <= full_r[i];
        end
      end
    end
  end

  // Saturating per-lane delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        count_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hs_s[i] && (count_r[i] != CNT_MAX)) begin
          count_r[i] <= count_r[i] + CNT_W'(1);
        end else begin
          count_r[i] <= count_r[i];
        end
      end
    end
  end

  // Pack the lane registers onto the flat output buses; these are straight
  // register taps, so nothing on the output side depends on out_ready.
  always_comb begin
    out_valid = full_r;
    out_data  = {(4*WIDTH){1'b0}};
    out_count = {(4*CNT_W){1'b0}};
    for (int i = 0; i < 4; i++) begin
      out_data[i*WIDTH +: WIDTH]  = data_r[i];
      out_count[i*CNT_W +: CNT_W] = count_r[i];
    end
  end

endmodule

// File: tb/tb_one_to_four_demux.sv
// ----------------------------------------------------------------------------
// tb_one_to_four_demux
//
// Two instances share every input: one with the default 8-bit counters and
// one with 2-bit counters to exercise saturation. A reference model holds a
// depth-one queue per lane and an unbounded handshake tally; expected counts
// are the tally clipped to each instance's maximum.
// ----------------------------------------------------------------------------
module tb_one_to_four_demux;

  localparam int W = 64;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_ready_b;
  logic [1:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_valid_b;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [4*W-1:0] out_data_b;
  logic [31:0]    out_count;
  logic [7:0]     out_count_b;

  one_to_four_demux #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  one_to_four_demux #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_count (out_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model
  logic [W-1:0] lane_q [4][$];
  logic [W-1:0] last_data [4];
  int           hs_tally [4];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      lane_q[i].delete();
      last_data[i] = '0;
      hs_tally[i]  = 0;
    end
  endtask

  function automatic logic model_ready();
    return (lane_q[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic acc;
    acc = in_valid && model_ready();
    for (int i = 0; i < 4; i++) begin
      if (lane_q[i].size() != 0 && out_ready[i]) begin
        void'(lane_q[i].pop_front());
        hs_tally[i]++;
      end
    end
    if (acc) begin
      lane_q[in_sel].push_back(in_data);
      last_data[in_sel] = in_data;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]     ev;
    logic [4*W-1:0] ed;
    logic [31:0]    ec;
    logic [7:0]     ecb;
    for (int i = 0; i < 4; i++) begin
      ev[i]           = (lane_q[i].size() != 0);
      ed[i*W +: W]    = last_data[i];
      ec[i*8 +: 8]    = 8'((hs_tally[i] > 255) ? 255 : hs_tally[i]);
      ecb[i*2 +: 2]   = 2'((hs_tally[i] > 3) ? 3 : hs_tally[i]);
    end
    check_eq({tag, "_valid"}, 256'(out_valid), 256'(ev));
    check_eq({tag, "_data"}, 256'(out_data), 256'(ed));
    check_eq({tag, "_count"}, 256'(out_count), 256'(ec));
    check_eq({tag, "_valid_b"}, 256'(out_valid_b), 256'(ev));
    check_eq({tag, "_count_b"}, 256'(out_count_b), 256'(ecb));
  endtask

  task automatic apply(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  // One clock: check ready before the edge, advance model, check registers after.
  task automatic cycle(input string tag);
    #1;
    check_eq({tag, "_in_ready"}, 256'(in_ready), 256'(model_ready()));
    check_eq({tag, "_in_ready_b"}, 256'(in_ready_b), 256'(model_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    model_reset();
    apply(1'b1, 2'd2, 64'hDEAD, 4'b0000);

    // Reset: ready high, no loads even with in_valid asserted across edges.
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 256'(in_ready), 256'(1'b1));
    check_eq("rst_valid", 256'(out_valid), 256'(4'b0000));
    check_eq("rst_data", 256'(out_data), 256'(0));
    check_eq("rst_count", 256'(out_count), 256'(0));
    rst_n = 1'b1;

    // Load lane 2, no consumer.
    apply(1'b1, 2'd2, 64'hA5, 4'b0000);
    cycle("ld2");
    check_eq("ld2_valid_k", 256'(out_valid), 256'(4'b0100));
    check_eq("ld2_data_k", 256'(out_data[2*W +: W]), 256'(64'hA5));
    apply(1'b1, 2'd2, 64'h77, 4'b0000);
    #1 check_eq("ld2_blocked_k", 256'(in_ready), 256'(1'b0));
    cycle("ld2_blk");

    // Consume and refill lane 2 in the same cycle.
    apply(1'b1, 2'd2, 64'h5A, 4'b0100);
    #1 check_eq("rf2_ready_k", 256'(in_ready), 256'(1'b1));
    cycle("rf2");
    check_eq("rf2_data_k", 256'(out_data[2*W +: W]), 256'(64'h5A));
    check_eq("rf2_count_k", 256'(out_count[2*8 +: 8]), 256'(8'd1));
    check_eq("rf2_valid_k", 256'(out_valid[2]), 256'(1'b1));

    // Drain lane 2, then fill all lanes.
    apply(1'b0, 2'd0, 64'h0, 4'b0100);
    cycle("dr2");
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'(i), 64'(1 << i), 4'b0000);
      cycle("fill");
    end
    check_eq("fill_valid_k", 256'(out_valid), 256'(4'b1111));
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'(i), 64'hFFFF, 4'b0000);
      #1 check_eq("full_ready_k", 256'(in_ready), 256'(1'b0));
      cycle("full_blk");
    end

    // Drain all lanes at once.
    apply(1'b0, 2'd0, 64'h0, 4'b1111);
    cycle("drall");
    check_eq("drall_valid_k", 256'(out_valid), 256'(4'b0000));
    check_eq("drall_count0_k", 256'(out_count[7:0]), 256'(8'd1));

    // Saturation of the 2-bit counter on lane 1.
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 2'd1, 64'(k + 16), 4'b0010);
      cycle("sat");
    end
    apply(1'b0, 2'd1, 64'h0, 4'b0010);
    cycle("sat_end");
    check_eq("sat_cnt_b_k", 256'(out_count_b[3:2]), 256'(2'd3));
    check_eq("sat_cnt_k", 256'(out_count[15:8]), 256'(8'd6));

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      cycle("rnd");
    end

    // Reset asserted between edges with lane 3 full.
    apply(1'b0, 2'd0, 64'h0, 4'b0000);
    cycle("pre3");
    apply(1'b1, 2'd3, 64'hC3, 4'b0000);
    cycle("ld3");
    apply(1'b0, 2'd0, 64'h0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 256'(out_valid), 256'(4'b0000));
    check_eq("mid_rst_count", 256'(out_count), 256'(0));
    check_eq("mid_rst_count_b", 256'(out_count_b), 256'(0));
    check_eq("mid_rst_data", 256'(out_data), 256'(0));
    check_eq("mid_rst_ready", 256'(in_ready), 256'(1'b1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 2'd3, 64'h3C, 4'b0000);
    cycle("post_rst");
    check_eq("post_rst_valid_k", 256'(out_valid), 256'(4'b1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
